dcache_store_buffer: RTL

- Sits between the L1 data cache miss/writeback port and the dcache port of l1_to_l2_cache_req_arbiter.
- Absorbs STORE requests into a small FIFO and acknowledges them immediately, then drains entries to the arbiter one at a time.
- Non-STORE requests (LOAD, any other memory_operation_e) pass through only after the buffer is empty, which preserves load-after-store ordering to L2.

---
 rtl/xentry_types.sv | 21 ++
 rtl/store_buffer_fifo.sv | 72 +++++++
 rtl/dcache_store_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/xentry_types.sv
// Shared request and store-buffer types for the L1 data cache request path.
// Latency: n/a (types only).
// Backpressure: n/a.
package xentry_types;

  // Memory operations presented on the dcache request port.
  typedef enum logic [1:0] {
    LOAD              = 2'd0,
    STORE             = 2'd1,
    LOAD_RESERVED     = 2'd2,
    STORE_CONDITIONAL = 2'd3
  } memory_operation_e;

  // Store buffer control states; independent of the arbiter's own FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } store_buffer_state_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// Store entry FIFO holding {address, data}; head is visible combinationally.
// Latency: a pushed entry is counted and visible at the head one cycle later.
// Backpressure: pushes are dropped when full, pops ignored when empty; the top gates both.
module store_buffer_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [XLEN-1:0]          push_address,
  input  logic [XLEN-1:0]          push_data,
  input  logic                     pop,
  output logic [XLEN-1:0]          head_address,
  output logic [XLEN-1:0]          head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot.
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;

  assign head_address = addr_mem[rd_ptr[AW-1:0]];
  assign head_data    = data_mem[rd_ptr[AW-1:0]];

  // Storage array: written at the tail slot; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr[AW-1:0]] <= push_address;
      data_mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers with wrap bit and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // The wrap-bit pointer distance must always agree with the count.
  count_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
    count_q == (wr_ptr - rd_ptr));

endmodule

// File: rtl/dcache_store_buffer.sv
// Store buffer between the L1 dcache miss port and the L2 request arbiter.
// Latency: stores acked in the request cycle; drained one per L2 handshake; loads pass through once empty.
// Backpressure: no store ack while full or while a load is in flight; loads wait for the buffer to empty.
module dcache_store_buffer
  import xentry_types::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [XLEN-1:0]          dcache_req_address,
  input  memory_operation_e        dcache_req_type,
  input  logic                     dcache_req_valid,
  input  logic [XLEN-1:0]          dcache_word_to_store,
  output logic [XLEN-1:0]          dcache_fetched_word,
  output logic                     dcache_req_fulfilled,
  output logic [XLEN-1:0]          req_address,
  output memory_operation_e        req_type,
  output logic                     req_valid,
  output logic [XLEN-1:0]          word_to_store,
  input  logic [XLEN-1:0]          fetched_word,
  input  logic                     req_fulfilled,
  output logic [$clog2(DEPTH):0]   buffer_count
);

  store_buffer_state_e state_q;
  store_buffer_state_e state_d;

  logic            full;
  logic            empty;
  logic [XLEN-1:0] head_address;
  logic [XLEN-1:0] head_data;
  logic            store_accept;
  logic            pop;

  // A store is absorbed whenever there is room, except while a load owns the L2 port.
  assign store_accept = !reset && dcache_req_valid && (dcache_req_type == STORE) &&
                        !full && (state_q != ST_LOAD);
  // Only a drain handshake retires an entry; stray fulfils in other states are ignored.
  assign pop = (state_q == ST_DRAIN) && req_fulfilled;

  store_buffer_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (store_accept),
    .push_address (dcache_req_address),
    .push_data    (dcache_word_to_store),
    .pop          (pop),
    .head_address (head_address),
    .head_data    (head_data),
    .full         (full),
    .empty        (empty),
    .count        (buffer_count)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output muxing; every fulfil returns to idle so L2 valid always has a gap.
  always_comb begin
    state_d              = state_q;
    req_address          = '0;
    req_type             = LOAD;
    req_valid            = 1'b0;
    word_to_store        = '0;
    dcache_fetched_word  = '0;
    dcache_req_fulfilled = store_accept;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_DRAIN;
        end else if (dcache_req_valid && (dcache_req_type != STORE)) begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        req_address   = head_address;
        word_to_store = head_data;
        req_type      = STORE;
        req_valid     = 1'b1;
        if (req_fulfilled) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        req_address          = dcache_req_address;
        req_type             = dcache_req_type;
        req_valid            = dcache_req_valid;
        dcache_fetched_word  = fetched_word;
        dcache_req_fulfilled = req_fulfilled;
        if (req_fulfilled) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are forced quiet for the whole reset window, not just after the first edge.
    if (reset) begin
      req_address          = '0;
      req_type             = LOAD;
      req_valid            = 1'b0;
      word_to_store        = '0;
      dcache_fetched_word  = '0;
      dcache_req_fulfilled = 1'b0;
    end
  end

endmodule
